// File: rtl/mem_pkg.sv
// Shared memory-access types: size encodings, lane payload and byte-enable helper.
package mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // One queued write in memory lane order
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } lane_wr_t;

    // Byte enables for an access; zero when misaligned or reserved size
    function automatic logic [BE_W-1:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
        logic [BE_W-1:0] be;
        be = '0;
        case (size_e'(size))
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: if (!lane[0]) be = 4'b0011 << lane;
            SZ_WORD: if (lane == 2'b00) be = 4'b1111;
            default: be = '0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store, load-check and memory-side signals of the store buffer.
interface store_buffer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [1:0]        st_size;
    logic              st_ready;
    logic              st_misaligned;

    logic [ADDR_W-1:0] ld_addr;
    logic [1:0]        ld_size;
    logic              ld_hit;
    logic [31:0]       ld_data;
    logic              ld_stall;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ready;
    logic              empty;

    // Processor and memory side
    modport master (
        output st_valid, st_addr, st_data, st_size, ld_addr, ld_size, mem_ready,
        input  st_ready, st_misaligned, ld_hit, ld_data, ld_stall,
               mem_we, mem_addr, mem_wdata, mem_be, empty
    );

    // Store buffer side
    modport slave (
        input  st_valid, st_addr, st_data, st_size, ld_addr, ld_size, mem_ready,
        output st_ready, st_misaligned, ld_hit, ld_data, ld_stall,
               mem_we, mem_addr, mem_wdata, mem_be, empty
    );
endinterface

// File: rtl/store_buffer_fwd.sv
// Youngest-match load forwarding over the queued entries, head to tail.
module store_buffer_fwd
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WA_W  = 30,
    parameter int unsigned PTR_W = 2,
    parameter int unsigned CNT_W = 3
) (
    input  logic [WA_W-1:0]  waddr_i [DEPTH],
    input  lane_wr_t         lane_i  [DEPTH],
    input  logic [PTR_W-1:0] head_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [WA_W-1:0]  ld_waddr_i,
    input  logic [3:0]       need_i,
    output logic             hit_o,
    output logic             stall_o,
    output logic [31:0]      data_o
);

    logic [3:0]       found;
    logic [3:0]       got;
    logic [31:0]      fwd;
    logic [31:0]      mask;
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so later matches overwrite earlier ones
    always_comb begin
        found = '0;
        fwd   = '0;
        mask  = '0;
        idx   = head_i;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if ((CNT_W'(i) < count_i) && (waddr_i[idx] == ld_waddr_i)) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (lane_i[idx].be[b]) begin
                        found[b]      = 1'b1;
                        fwd[8*b +: 8] = lane_i[idx].data[8*b +: 8];
                    end
                end
            end
        end
        for (int unsigned b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{need_i[b]}};
        end
        got     = found & need_i;
        hit_o   = (need_i != 4'b0000) && (got == need_i);
        stall_o = (got != 4'b0000) && (got != need_i);
        data_o  = fwd & mask;
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: converts stores to lane writes, queues them, drains to memory in order.
module store_buffer
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WA_W  = ADDR_W - 2;

    logic [WA_W-1:0]  waddr_q [DEPTH];
    lane_wr_t         lane_q  [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [3:0]  st_be;
    logic [31:0] st_lanes;
    logic        st_bad;
    logic        full;
    logic        empty_w;
    logic        enq;
    logic        deq;
    logic [3:0]  ld_need;

    // Store conversion into lane-positioned data and byte enables
    always_comb begin
        st_be  = lane_be(sb.st_size, sb.st_addr[1:0]);
        st_bad = (st_be == 4'b0000);
        case (size_e'(sb.st_size))
            SZ_BYTE: st_lanes = {4{sb.st_data[7:0]}};
            SZ_HALF: st_lanes = {2{sb.st_data[15:0]}};
            default: st_lanes = sb.st_data;
        endcase
    end

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_w = (count_q == '0);
    assign enq     = sb.st_valid & ~full & ~st_bad;
    assign deq     = ~empty_w & sb.mem_ready;

    // Pointer and occupancy next state
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq) head_d = head_q + PTR_W'(1);
        if (enq) tail_d = tail_q + PTR_W'(1);
        if (enq && !deq) begin
            count_d = count_q + CNT_W'(1);
        end else if (!enq && deq) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; only slots between head and tail are ever read
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            waddr_q[tail_q] <= sb.st_addr[ADDR_W-1:2];
            lane_q[tail_q]  <= '{data: st_lanes, be: st_be};
        end
    end

    assign sb.st_ready     = ~full;
    assign sb.st_misaligned = sb.st_valid & st_bad;
    assign sb.empty        = empty_w;
    assign sb.mem_we       = ~empty_w;
    assign sb.mem_addr     = empty_w ? '0 : {waddr_q[head_q], 2'b00};
    assign sb.mem_wdata    = empty_w ? '0 : lane_q[head_q].data;
    assign sb.mem_be       = empty_w ? '0 : lane_q[head_q].be;

    assign ld_need = lane_be(sb.ld_size, sb.ld_addr[1:0]);

    store_buffer_fwd #(
        .DEPTH (DEPTH),
        .WA_W  (WA_W),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_fwd (
        .waddr_i    (waddr_q),
        .lane_i     (lane_q),
        .head_i     (head_q),
        .count_i    (count_q),
        .ld_waddr_i (sb.ld_addr[ADDR_W-1:2]),
        .need_i     (ld_need),
        .hit_o      (sb.ld_hit),
        .stall_o    (sb.ld_stall),
        .data_o     (sb.ld_data)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer against a queue-based reference model.
`timescale 1ns/1ps
module tb_store_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 32;

    typedef struct {
        logic [31:0] wa;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    logic clk = 1'b0;
    logic rst;

    store_buffer_if #(.ADDR_W(ADDR_W)) sbif ();

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (rst),
        .sb    (sbif)
    );

    always #5 clk = ~clk;

    int   nvec = 0;
    int   nerr = 0;
    ent_t q[$];
    ent_t exp_wr[$];
    ent_t dut_wr[$];

    // Needed lanes: naturally aligned accesses of 1, 2 or 4 bytes
    function automatic logic [3:0] ref_need(input logic [1:0] size, input logic [31:0] addr);
        int nbytes;
        int lane;
        nbytes = 1 << size;
        lane   = int'(addr % 4);
        if (size == 2'd3 || (addr % nbytes) != 0) return 4'b0000;
        return 4'(((1 << nbytes) - 1) << lane);
    endfunction

    // Replicate the right-justified store data across all lanes
    function automatic logic [31:0] ref_lanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] r;
        int nbytes;
        nbytes = (size == 2'd3) ? 4 : (1 << size);
        for (int b = 0; b < 4; b++) r[8*b +: 8] = data[8*(b % nbytes) +: 8];
        return r;
    endfunction

    // Load lookup: youngest entry per needed byte
    task automatic ref_load(input logic [31:0] addr, input logic [1:0] size,
                            output logic hit, output logic stall, output logic [31:0] data);
        logic [3:0] need;
        int found;
        int nneed;
        need  = ref_need(size, addr);
        found = 0;
        data  = '0;
        for (int b = 0; b < 4; b++) begin
            if (need[b]) begin
                for (int j = q.size() - 1; j >= 0; j--) begin
                    if (q[j].wa == {addr[31:2], 2'b00} && q[j].be[b]) begin
                        found++;
                        data[8*b +: 8] = q[j].d[8*b +: 8];
                        break;
                    end
                end
            end
        end
        nneed = $countones(need);
        hit   = (nneed > 0) && (found == nneed);
        stall = (found > 0) && (found < nneed);
    endtask

    // Advance one clock, updating the model and logging memory writes
    task automatic cycle();
        bit   enq;
        bit   deq;
        ent_t e;
        ent_t w;
        enq = sbif.st_valid && (q.size() < DEPTH) && (ref_need(sbif.st_size, sbif.st_addr) != 4'b0000);
        deq = (q.size() > 0) && sbif.mem_ready;
        e.wa = {sbif.st_addr[31:2], 2'b00};
        e.d  = ref_lanes(sbif.st_size, sbif.st_data);
        e.be = ref_need(sbif.st_size, sbif.st_addr);
        if (!rst && sbif.mem_we && sbif.mem_ready) begin
            w.wa = sbif.mem_addr;
            w.d  = sbif.mem_wdata;
            w.be = sbif.mem_be;
            dut_wr.push_back(w);
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (deq) begin
                exp_wr.push_back(q[0]);
                void'(q.pop_front());
            end
            if (enq) q.push_back(e);
        end
        #1;
    endtask

    task automatic idle();
        sbif.st_valid = 1'b0;
        sbif.st_addr  = '0;
        sbif.st_data  = '0;
        sbif.st_size  = 2'd0;
        sbif.ld_addr  = '0;
        sbif.ld_size  = 2'd3;
    endtask

    task automatic store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        sbif.st_valid = 1'b1;
        sbif.st_size  = size;
        sbif.st_addr  = addr;
        sbif.st_data  = data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        sbif.mem_ready = 1'b0;
        sbif.ld_size   = 2'd2;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        nvec++; if ({sbif.st_ready, sbif.empty, sbif.mem_we} !== 3'b110) begin nerr++;
            $display("FAIL reset_flags: got rdy/empty/we=%b want 110", {sbif.st_ready, sbif.empty, sbif.mem_we}); end
        nvec++; if ({sbif.mem_addr, sbif.mem_wdata, sbif.mem_be} !== '0) begin nerr++;
            $display("FAIL reset_mem: got addr=%h wdata=%h be=%b want 0", sbif.mem_addr, sbif.mem_wdata, sbif.mem_be); end
        nvec++; if ({sbif.ld_hit, sbif.ld_stall} !== 2'b00) begin nerr++;
            $display("FAIL reset_ld: got hit/stall=%b want 00", {sbif.ld_hit, sbif.ld_stall}); end
    endtask

    task automatic test_word_store();
        sbif.mem_ready = 1'b1;
        store(2'd2, 32'd8, 32'h0000_0004);
        cycle();
        idle();
        #1;
        nvec++; if ({sbif.mem_we, sbif.mem_addr, sbif.mem_be, sbif.mem_wdata} !== {1'b1, 32'd8, 4'b1111, 32'h4}) begin nerr++;
            $display("FAIL word_store: got we=%b addr=%h be=%b wdata=%h want 1/8/1111/4",
                     sbif.mem_we, sbif.mem_addr, sbif.mem_be, sbif.mem_wdata); end
        cycle();
        nvec++; if (sbif.empty !== 1'b1) begin nerr++;
            $display("FAIL word_drain: got empty=%b want 1", sbif.empty); end
    endtask

    task automatic test_byte_store();
        sbif.mem_ready = 1'b0;
        store(2'd0, 32'd17, 32'h0000_00AA);
        cycle();
        idle();
        #1;
        nvec++; if ({sbif.mem_addr, sbif.mem_be, sbif.mem_wdata[15:8]} !== {32'd16, 4'b0010, 8'hAA}) begin nerr++;
            $display("FAIL byte_store: got addr=%h be=%b lane1=%h want 10/0010/aa",
                     sbif.mem_addr, sbif.mem_be, sbif.mem_wdata[15:8]); end
        sbif.mem_ready = 1'b1;
        cycle();
        nvec++; if (sbif.empty !== 1'b1) begin nerr++;
            $display("FAIL byte_drain: got empty=%b want 1", sbif.empty); end
    endtask

    task automatic test_misaligned();
        logic [1:0]  sz [2];
        logic [31:0] ad [2];
        sz[0] = 2'd1; ad[0] = 32'd25;
        sz[1] = 2'd2; ad[1] = 32'd26;
        sbif.mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            store(sz[k], ad[k], 32'h1234_5678);
            #1;
            nvec++; if (sbif.st_misaligned !== 1'b1) begin nerr++;
                $display("FAIL misaligned_flag%0d: got %b want 1", k, sbif.st_misaligned); end
            cycle();
            idle();
            #1;
            nvec++; if ({sbif.empty, sbif.mem_we} !== 2'b10) begin nerr++;
                $display("FAIL misaligned_drop%0d: got empty/we=%b want 10", k, {sbif.empty, sbif.mem_we}); end
        end
    endtask

    task automatic test_full();
        sbif.mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            store(2'd2, 32'(4 * k), 32'h100 + 32'(k));
            #1;
            nvec++; if (sbif.st_ready !== (k < 4)) begin nerr++;
                $display("FAIL full_ready%0d: got %b want %b", k, sbif.st_ready, k < 4); end
            cycle();
        end
        idle();
        sbif.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k == 0) begin
                nvec++; if (sbif.st_ready !== 1'b0) begin nerr++;
                    $display("FAIL full_ready_hold: got %b want 0", sbif.st_ready); end
            end
            nvec++; if ({sbif.mem_addr, sbif.mem_wdata} !== {32'(4 * k), 32'h100 + 32'(k)}) begin nerr++;
                $display("FAIL full_drain%0d: got addr=%h data=%h want %h/%h", k, sbif.mem_addr,
                         sbif.mem_wdata, 32'(4 * k), 32'h100 + 32'(k)); end
            cycle();
        end
        nvec++; if ({sbif.empty, sbif.st_ready} !== 2'b11) begin nerr++;
            $display("FAIL full_end: got empty/ready=%b want 11", {sbif.empty, sbif.st_ready}); end
    endtask

    task automatic test_forwarding();
        sbif.mem_ready = 1'b0;
        store(2'd2, 32'd24, 32'hFFFF_BEEF);
        cycle();
        store(2'd0, 32'd25, 32'h0000_0011);
        cycle();
        idle();
        sbif.ld_addr = 32'd24;
        sbif.ld_size = 2'd1;
        #1;
        nvec++; if ({sbif.ld_hit, sbif.ld_stall, sbif.ld_data} !== {2'b10, 32'h0000_11EF}) begin nerr++;
            $display("FAIL fwd_half: got hit=%b stall=%b data=%h want 1/0/000011ef",
                     sbif.ld_hit, sbif.ld_stall, sbif.ld_data); end
        sbif.ld_addr = 32'd28;
        sbif.ld_size = 2'd2;
        #1;
        nvec++; if ({sbif.ld_hit, sbif.ld_stall} !== 2'b00) begin nerr++;
            $display("FAIL fwd_miss: got hit/stall=%b want 00", {sbif.ld_hit, sbif.ld_stall}); end
        sbif.mem_ready = 1'b1;
        cycle();
        cycle();
    endtask

    task automatic test_partial_reset();
        int n;
        sbif.mem_ready = 1'b0;
        store(2'd0, 32'd24, 32'h0000_005A);
        cycle();
        idle();
        sbif.ld_addr = 32'd24;
        sbif.ld_size = 2'd2;
        #1;
        nvec++; if ({sbif.ld_hit, sbif.ld_stall} !== 2'b01) begin nerr++;
            $display("FAIL partial_stall: got hit/stall=%b want 01", {sbif.ld_hit, sbif.ld_stall}); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        nvec++; if ({sbif.empty, sbif.ld_stall, sbif.mem_we} !== 3'b100) begin nerr++;
            $display("FAIL partial_reset: got empty/stall/we=%b want 100", {sbif.empty, sbif.ld_stall, sbif.mem_we}); end
        n = dut_wr.size();
        sbif.mem_ready = 1'b1;
        cycle();
        nvec++; if (dut_wr.size() !== n) begin nerr++;
            $display("FAIL partial_nowrite: got %0d writes want %0d", dut_wr.size(), n); end
    endtask

    task automatic test_random();
        logic        ehit;
        logic        estall;
        logic [31:0] edata;
        logic [31:0] eaddr;
        logic [31:0] ewd;
        logic [3:0]  ebe;
        logic        ebad;
        exp_wr.delete();
        dut_wr.delete();
        for (int c = 0; c < 400; c++) begin
            rst            = ($urandom_range(0, 59) == 0);
            sbif.st_valid  = ($urandom_range(0, 2) != 0);
            sbif.st_addr   = 32'($urandom_range(0, 23));
            sbif.st_size   = 2'($urandom_range(0, 3));
            sbif.st_data   = $urandom;
            sbif.mem_ready = ($urandom_range(0, 2) == 0);
            sbif.ld_addr   = 32'($urandom_range(0, 23));
            sbif.ld_size   = 2'($urandom_range(0, 2));
            #1;
            ref_load(sbif.ld_addr, sbif.ld_size, ehit, estall, edata);
            nvec++; if ({sbif.ld_hit, sbif.ld_stall} !== {ehit, estall}) begin nerr++;
                $display("FAIL rnd_ld%0d: got hit/stall=%b%b want %b%b", c, sbif.ld_hit, sbif.ld_stall, ehit, estall); end
            if (ehit) begin
                nvec++; if (sbif.ld_data !== edata) begin nerr++;
                    $display("FAIL rnd_lddata%0d: got %h want %h", c, sbif.ld_data, edata); end
            end
            ebad = sbif.st_valid && (ref_need(sbif.st_size, sbif.st_addr) == 4'b0000);
            nvec++; if (sbif.st_misaligned !== ebad) begin nerr++;
                $display("FAIL rnd_mis%0d: got %b want %b", c, sbif.st_misaligned, ebad); end
            nvec++; if ({sbif.st_ready, sbif.empty, sbif.mem_we} !== {q.size() < DEPTH, q.size() == 0, q.size() != 0}) begin nerr++;
                $display("FAIL rnd_flags%0d: got rdy/empty/we=%b model count %0d", c,
                         {sbif.st_ready, sbif.empty, sbif.mem_we}, q.size()); end
            eaddr = (q.size() != 0) ? q[0].wa : '0;
            ewd   = (q.size() != 0) ? q[0].d  : '0;
            ebe   = (q.size() != 0) ? q[0].be : '0;
            nvec++; if ({sbif.mem_addr, sbif.mem_wdata, sbif.mem_be} !== {eaddr, ewd, ebe}) begin nerr++;
                $display("FAIL rnd_head%0d: got %h/%h/%b want %h/%h/%b", c, sbif.mem_addr, sbif.mem_wdata,
                         sbif.mem_be, eaddr, ewd, ebe); end
            cycle();
        end
        rst = 1'b0;
        nvec++; if (dut_wr.size() !== exp_wr.size()) begin nerr++;
            $display("FAIL rnd_wrcount: got %0d want %0d", dut_wr.size(), exp_wr.size()); end
        for (int i = 0; i < exp_wr.size() && i < dut_wr.size(); i++) begin
            nvec++; if ({dut_wr[i].wa, dut_wr[i].d, dut_wr[i].be} !== {exp_wr[i].wa, exp_wr[i].d, exp_wr[i].be}) begin nerr++;
                $display("FAIL rnd_wr%0d: got %h/%h/%b want %h/%h/%b", i, dut_wr[i].wa, dut_wr[i].d,
                         dut_wr[i].be, exp_wr[i].wa, exp_wr[i].d, exp_wr[i].be); end
        end
    endtask

    initial begin
        rst = 1'b1;
        sbif.mem_ready = 1'b0;
        idle();
        test_reset();
        test_word_store();
        test_byte_store();
        test_misaligned();
        test_full();
        test_forwarding();
        test_partial_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Registered store buffer between the processor's store datapath and `dmemory`. It accepts store requests (byte, halfword, word) from the execute stage, converts each to a little-endian byte-lane write, and queues it. It drains the queue into data memory one entry per accepted memory cycle. Loads check it combinationally, so a load returns forwarded data or stalls instead of reading stale memory.

## Interface
- `DEPTH`, 4: number of queued entries; power of two, at least 2.
- `ADDR_W`, 32: byte-address width.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge.
- `st_valid`  in  1  store request present this cycle.
- `st_addr`  in  ADDR_W  store byte address.
- `st_data`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `st_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `st_ready`  out  1  buffer can accept a store this cycle.
- `st_misaligned`  out  1  current request is misaligned or reserved-size; it is not enqueued.
- `ld_addr`  in  ADDR_W  load byte address, checked combinationally.
- `ld_size`  in  2  same encoding as `st_size`.
- `ld_hit`  out  1  buffer fully supplies the load bytes.
- `ld_data`  out  32  forwarded word in memory lane order; meaningful only when `ld_hit`.
- `ld_stall`  out  1  partial overlap; the load must wait for the buffer to drain.
- `mem_we`  out  1  head entry is presented to memory.
- `mem_addr`  out  ADDR_W  word-aligned address; low 2 bits are 0.
- `mem_wdata`  out  32  lane-positioned data.
- `mem_be`  out  4  byte enables; bit i writes byte `mem_addr+i`.
- `mem_ready`  in  1  memory accepts the head this cycle.
- `empty`  out  1  no entries queued.

## Operation
- **Store conversion**, where lane = `st_addr[1:0]`:
  - byte: `be = 1<<lane`; data[7:0] is replicated to all lanes.
  - half: lane must be 0 or 2; `be = 2'b11<<lane`; data[15:0] is replicated to both halves.
  - word: lane must be 0; `be = 4'b1111`.
  - Stored word address = `{st_addr[ADDR_W-1:2],2'b00}`.
- **Misaligned request:** `st_misaligned = st_valid & (size 11, or half with odd lane, or word with lane≠0)`. The request is dropped and state is unchanged. `st_ready` is unaffected.
- **Enqueue:** happens when `st_valid & st_ready & ~st_misaligned`. Entry holds {word address, 32-bit data, be}.
- **`st_ready`:** equals `count < DEPTH`. There is no same-cycle pass-through when full.
- **Dequeue:** happens when `mem_we & mem_ready`. `mem_we = ~empty`. `mem_addr`, `mem_wdata` and `mem_be` are driven directly from the head entry.
- **Storage:** circular queue with wrapping head and tail pointers and a count from 0 to DEPTH. Simultaneous enqueue and dequeue leaves count unchanged.
- **Entries are never coalesced.** Program order is preserved to memory.
- **Load check** covers queued entries only; the same-cycle incoming store is excluded.
  - Needed lanes `need` are computed as in store conversion from `ld_addr`/`ld_size`. A misaligned load gives `need = 0`, so the load neither hits nor stalls.
  - Each needed byte takes its value from the youngest entry with a matching word address and that lane enabled.
  - `ld_hit = 1` when every needed byte is found in the buffer.
  - `ld_stall = 1` when some, but not all, needed bytes are found.
  - When no needed byte is found, both are 0 and the load reads memory.
  - `ld_hit` and `ld_stall` are mutually exclusive. Unneeded lanes of `ld_data` are 0.

## Timing
- **Reset values:** pointers 0, count 0, `st_ready` 1, `empty` 1, `mem_we` 0, `mem_be` 0, `mem_addr` 0, `mem_wdata` 0, `ld_hit` 0, `ld_stall` 0.
- **Reset mid-operation:** all queued entries are discarded without being written. A store or dequeue in the reset cycle has no effect.
- **Latency:** a store accepted at edge N is visible on `mem_*` and to the load check after edge N. Its earliest memory write is at edge N+1.
- **Throughput:** one enqueue and one dequeue per cycle sustained.
- **Timing of `mem_ready`:**
  - `mem_ready` while `empty` is ignored.
  - `mem_ready` low holds the head and all `mem_*` outputs stable.
- **Full, with `mem_ready` high:** `st_ready` stays 0 this cycle and returns to 1 after the edge.
- **Outputs that are combinational from inputs:** `ld_hit`, `ld_stall`, `ld_data`, `st_misaligned`. All others are registered-state outputs.

## Structure
- **Shared `mem_pkg`:** size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`, and a lane/byte-enable function used by both store conversion and the load check.
- **Sub-module `store_buffer_fwd`:** combinational youngest-match forwarding network over the entry array, ordered from head to tail.
- The FIFO and conversion logic remain in `store_buffer`.

## Test plan
- **Word store:** word store of `0x00000004` at addr 8, `mem_ready=1`.
  - Next cycle: `mem_we=1`, `mem_addr=8`, `mem_be=1111`, `mem_wdata=0x00000004`.
  - Following cycle: `empty=1`.
- **Byte store:** byte store of `0xAA` at addr 17 → `mem_addr=16`, `mem_be=0010`, `mem_wdata[15:8]=0xAA`.
- **Misaligned stores:** halfword at addr 25, then word at addr 26 → `st_misaligned=1` both times, count stays 0, `mem_we` stays 0.
- **Full queue:** `mem_ready=0`, five back-to-back word stores to 0, 4, 8, 12, 16.
  - `st_ready=0` after the fourth; the fifth is not accepted.
  - Raising `mem_ready` drains 0, 4, 8, 12 in order.
- **Forwarding:** queue word `0xFFFFBEEF` at 24, then byte `0x11` at 25.
  - Load half at 24 → `ld_hit=1`, `ld_data=0x000011EF`.
  - Load word at 28 → `ld_hit=0`, `ld_stall=0`.
- **Partial overlap and reset:** queue byte at 24; load word at 24 → `ld_stall=1`. Assert `reset` → next cycle `empty=1`, `ld_stall=0`, and no memory write occurs.
